// File: rtl/fp16_result_collector.sv
// fp16_result_collector
// Receives the fp16 add/sub result stream, which has no back-pressure, and
// buffers {tuser,tdata} in a circular FIFO. The head entry is re-issued on a
// back-pressurable AXI-stream from registered outputs, with first-word
// fall-through and 1-cycle latency.
// Sticky exception flags and a sticky drop error are kept for the controller.
// Optional build macro FP16_RES_CNT_EN adds saturating per-flag and drop event
// counters.
module fp16_result_collector #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          s_axis_res_tvalid,
  input  logic [15:0]   s_axis_res_tdata,
  input  logic [2:0]    s_axis_res_tuser,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [15:0]   m_axis_tdata,
  output logic [2:0]    m_axis_tuser,
  output logic [AW:0]   level,
  output logic [2:0]    exc_sticky,
  output logic          drop_err,
`ifdef FP16_RES_CNT_EN
  output logic [15:0]   underflow_cnt,
  output logic [15:0]   overflow_cnt,
  output logic [15:0]   invalid_cnt,
  output logic [15:0]   drop_cnt,
`endif
  input  logic          clr
);

  localparam int W = 19;

  logic [W-1:0]  mem [DEPTH];

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          tvalid_q, tvalid_d;
  logic [W-1:0]  out_q, out_d;
  logic [2:0]    sticky_q, sticky_d;
  logic          drop_err_q, drop_err_d;

  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic [W-1:0]  in_word;
  logic [W-1:0]  head;

  // Push/pop/drop decisions, pointer and level updates, next head selection.
  always_comb begin
    in_word  = {s_axis_res_tuser, s_axis_res_tdata};
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = tvalid_q & m_axis_tready;
    push     = s_axis_res_tvalid & (~full | pop);
    drop     = s_axis_res_tvalid & full & ~pop;

    wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (pop && !push) begin
      level_d = level_q - (AW+1)'(1);
    end

    tvalid_d = (wr_ptr_d != rd_ptr_d);

    // When the write slot equals the next head slot, the FIFO is empty after
    // this cycle's pop, so the incoming beat becomes the head directly.
    if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      head = in_word;
    end else begin
      head = mem[rd_ptr_d[AW-1:0]];
    end
    out_d    = tvalid_d ? head : out_q;

    sticky_d   = (clr ? 3'b000 : sticky_q) | (push ? s_axis_res_tuser : 3'b000);
    drop_err_d = (clr ? 1'b0 : drop_err_q) | drop;
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= in_word;
    end
  end

  // Control and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tvalid_q   <= 1'b0;
      out_q      <= '0;
      sticky_q   <= 3'b000;
      drop_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tvalid_q   <= tvalid_d;
      out_q      <= out_d;
      sticky_q   <= sticky_d;
      drop_err_q <= drop_err_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = out_q[15:0];
  assign m_axis_tuser  = out_q[18:16];
  assign level         = level_q;
  assign exc_sticky    = sticky_q;
  assign drop_err      = drop_err_q;

`ifdef FP16_RES_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;
  logic [15:0] ocnt_q, ocnt_d;
  logic [15:0] icnt_q, icnt_d;
  logic [15:0] dcnt_q, dcnt_d;

  // Saturating counter step; clr restarts the count, keeping a coincident event.
  function automatic logic [15:0] cnt_step(input logic [15:0] c,
                                           input logic inc,
                                           input logic clr_i);
    logic [15:0] r;
    if (clr_i) begin
      r = inc ? 16'd1 : 16'd0;
    end else if (inc && (c != 16'hFFFF)) begin
      r = c + 16'd1;
    end else begin
      r = c;
    end
    return r;
  endfunction

  // Next counter values.
  always_comb begin
    ucnt_d = cnt_step(ucnt_q, push & s_axis_res_tuser[0], clr);
    ocnt_d = cnt_step(ocnt_q, push & s_axis_res_tuser[1], clr);
    icnt_d = cnt_step(icnt_q, push & s_axis_res_tuser[2], clr);
    dcnt_d = cnt_step(dcnt_q, drop, clr);
  end

  // Counter registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ucnt_q <= '0;
      ocnt_q <= '0;
      icnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
      ocnt_q <= ocnt_d;
      icnt_q <= icnt_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign underflow_cnt = ucnt_q;
  assign overflow_cnt  = ocnt_q;
  assign invalid_cnt   = icnt_q;
  assign drop_cnt      = dcnt_q;
`endif

endmodule

// File: tb/tb_fp16_result_collector.sv
// Bench for fp16_result_collector: directed steps from the feature list, then
// random traffic, all compared against a queue-based reference model.
module tb_fp16_result_collector;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          s_axis_res_tvalid;
  logic [15:0]   s_axis_res_tdata;
  logic [2:0]    s_axis_res_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [15:0]   m_axis_tdata;
  logic [2:0]    m_axis_tuser;
  logic [AW:0]   level;
  logic [2:0]    exc_sticky;
  logic          drop_err;
  logic          clr;
`ifdef FP16_RES_CNT_EN
  logic [15:0]   underflow_cnt, overflow_cnt, invalid_cnt, drop_cnt;
`endif

  fp16_result_collector #(.DEPTH(DEPTH), .AW(AW)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .s_axis_res_tvalid (s_axis_res_tvalid),
    .s_axis_res_tdata  (s_axis_res_tdata),
    .s_axis_res_tuser  (s_axis_res_tuser),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tuser      (m_axis_tuser),
    .level             (level),
    .exc_sticky        (exc_sticky),
    .drop_err          (drop_err),
`ifdef FP16_RES_CNT_EN
    .underflow_cnt     (underflow_cnt),
    .overflow_cnt      (overflow_cnt),
    .invalid_cnt       (invalid_cnt),
    .drop_cnt          (drop_cnt),
`endif
    .clr               (clr)
  );

  always #5 aclk = ~aclk;

  int nerr = 0;
  int nchk = 0;

  // Reference model: queue of {tuser,tdata}, sticky flags, event counters.
  logic [18:0] q[$];
  logic [2:0]  m_sticky;
  logic        m_derr;
  int          m_ucnt, m_ocnt, m_icnt, m_dcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_sticky = 3'b000;
    m_derr   = 1'b0;
    m_ucnt = 0; m_ocnt = 0; m_icnt = 0; m_dcnt = 0;
  endtask

  function automatic int cstep(input int c, input bit inc, input bit cl);
    if (cl) return inc ? 1 : 0;
    if (inc && c < 65535) return c + 1;
    return c;
  endfunction

  task automatic check_all(input string ctx);
    chk({ctx, ".tvalid"}, 32'(m_axis_tvalid), 32'(q.size() > 0));
    chk({ctx, ".level"}, 32'(level), 32'(q.size()));
    if (q.size() > 0) begin
      chk({ctx, ".tdata"}, 32'(m_axis_tdata), 32'(q[0][15:0]));
      chk({ctx, ".tuser"}, 32'(m_axis_tuser), 32'(q[0][18:16]));
    end
    chk({ctx, ".sticky"}, 32'(exc_sticky), 32'(m_sticky));
    chk({ctx, ".drop_err"}, 32'(drop_err), 32'(m_derr));
`ifdef FP16_RES_CNT_EN
    chk({ctx, ".ucnt"}, 32'(underflow_cnt), 32'(m_ucnt));
    chk({ctx, ".ocnt"}, 32'(overflow_cnt), 32'(m_ocnt));
    chk({ctx, ".icnt"}, 32'(invalid_cnt), 32'(m_icnt));
    chk({ctx, ".dcnt"}, 32'(drop_cnt), 32'(m_dcnt));
`endif
  endtask

  // One clock: drive inputs, step the model across the edge, check outputs.
  task automatic cyc(input string ctx, input bit v, input logic [15:0] d,
                     input logic [2:0] u, input bit r, input bit c);
    bit full, pop, push, drop;
    s_axis_res_tvalid = v;
    s_axis_res_tdata  = d;
    s_axis_res_tuser  = u;
    m_axis_tready     = r;
    clr               = c;
    full = (q.size() == DEPTH);
    pop  = (q.size() > 0) && r;
    push = v && (!full || pop);
    drop = v && full && !pop;
    @(posedge aclk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back({u, d});
    m_sticky = (c ? 3'b000 : m_sticky) | (push ? u : 3'b000);
    m_derr   = (c ? 1'b0 : m_derr) | drop;
    m_ucnt = cstep(m_ucnt, push && u[0], c);
    m_ocnt = cstep(m_ocnt, push && u[1], c);
    m_icnt = cstep(m_icnt, push && u[2], c);
    m_dcnt = cstep(m_dcnt, drop, c);
    check_all(ctx);
  endtask

  task automatic check_reset_outputs(input string ctx);
    chk({ctx, ".tvalid0"}, 32'(m_axis_tvalid), 32'd0);
    chk({ctx, ".tdata0"},  32'(m_axis_tdata),  32'd0);
    chk({ctx, ".tuser0"},  32'(m_axis_tuser),  32'd0);
    chk({ctx, ".level0"},  32'(level),         32'd0);
    chk({ctx, ".sticky0"}, 32'(exc_sticky),    32'd0);
    chk({ctx, ".derr0"},   32'(drop_err),      32'd0);
  endtask

  logic [15:0] burst [8];

  initial begin
    burst[0] = 16'h7935; burst[1] = 16'h7812; burst[2] = 16'h7a40; burst[3] = 16'h76c1;
    burst[4] = 16'h7b0f; burst[5] = 16'h7399; burst[6] = 16'h7444; burst[7] = 16'h7502;
    aresetn = 1'b0;
    s_axis_res_tvalid = 1'b0;
    s_axis_res_tdata  = 16'h0;
    s_axis_res_tuser  = 3'b000;
    m_axis_tready     = 1'b0;
    clr               = 1'b0;
    model_clear();
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("reset");
    aresetn = 1'b1;

    // Single beat through an empty FIFO with the sink ready.
    cyc("single_push", 1, 16'hcc3e, 3'b000, 1, 0);
    chk("single_latency", 32'(m_axis_tdata), 32'h0000cc3e);
    cyc("single_pop", 0, 16'h0, 3'b000, 1, 0);
    chk("single_empty", 32'(level), 32'd0);

    // Fill to full with the sink stalled; overflow flag on the third beat.
    for (int i = 0; i < 8; i++)
      cyc("fill", 1, burst[i], (i == 2) ? 3'b010 : 3'b000, 0, 0);
    chk("fill_level", 32'(level), 32'd8);
    chk("fill_sticky", 32'(exc_sticky), 32'd2);
    chk("fill_head", 32'(m_axis_tdata), 32'h00007935);
    cyc("hold", 0, 16'h0, 3'b000, 0, 0);
    chk("hold_head", 32'(m_axis_tdata), 32'h00007935);

    // Push into a full, stalled FIFO: dropped.
    cyc("drop", 1, 16'h770d, 3'b001, 0, 0);
    chk("drop_err_set", 32'(drop_err), 32'd1);
    chk("drop_level", 32'(level), 32'd8);
    cyc("clr_drop", 0, 16'h0, 3'b000, 0, 1);
    chk("clr_drop_err", 32'(drop_err), 32'd0);

    // Full FIFO with simultaneous pop and push: accepted.
    cyc("full_pushpop", 1, 16'hf758, 3'b000, 1, 0);
    chk("fpp_level", 32'(level), 32'd8);
    chk("fpp_derr", 32'(drop_err), 32'd0);
    for (int i = 0; i < 8; i++) cyc("drain", 0, 16'h0, 3'b000, 1, 0);
    chk("drain_empty", 32'(m_axis_tvalid), 32'd0);

    // Set overflow flag, then clr coincident with an invalid-op push.
    cyc("set_ovf", 1, 16'h7bff, 3'b010, 1, 0);
    cyc("clr_push", 1, 16'h7e00, 3'b100, 1, 1);
    chk("clr_new_wins", 32'(exc_sticky), 32'd4);
    cyc("clr_drain", 0, 16'h0, 3'b000, 1, 0);
    cyc("clr_drain2", 0, 16'h0, 3'b000, 1, 0);

    // Reset mid-burst at level 5.
    for (int i = 0; i < 5; i++) cyc("pre_rst", 1, 16'(16'h3c00 + i), 3'b001, 0, 0);
    chk("pre_rst_level", 32'(level), 32'd5);
    #2 aresetn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    model_clear();
    @(posedge aclk);
    #1 aresetn = 1'b1;
    cyc("post_rst", 1, 16'h4248, 3'b000, 0, 0);
    chk("post_rst_head", 32'(m_axis_tdata), 32'h00004248);
    cyc("post_rst_pop", 0, 16'h0, 3'b000, 1, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] u;
      u = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      cyc("rand", ($urandom_range(0, 2) != 0), 16'($urandom), u,
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
